// File: rtl/uart_word_assembler_pkg.sv
// Shared constants and state encoding for the UART word assembler.
// Optional inter-byte timeout is enabled with UART_WORD_ASSEMBLER_TIMEOUT_EN.
package uart_word_assembler_pkg;

  localparam int NB_DATA_DEF        = 32;
  localparam int NB_BYTE_DEF        = 8;
  localparam int BYTES_PER_WORD     = NB_DATA_DEF / NB_BYTE_DEF;
  localparam int NB_TIMEOUT_DEF     = 16;
  localparam int TIMEOUT_CYCLES_DEF = 50000;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/uart_word_assembler_rx_timeout_counter.sv
// Inter-byte idle counter; expired is asserted on the cycle whose edge
// completes TIMEOUT_CYCLES consecutive running clocks.
module rx_timeout_counter #(
  parameter int NB_TIMEOUT     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam logic [NB_TIMEOUT-1:0] LAST_CNT = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMEOUT-1:0] cnt_q;

  assign o_expired = i_run && (cnt_q == LAST_CNT);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else if (i_clear || o_expired) begin
      cnt_q <= '0;
    end else if (i_run) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_word_assembler.sv
// Reassembles UART bytes (LSB byte first) into words on a valid/ready output.
// Define UART_WORD_ASSEMBLER_TIMEOUT_EN to discard stale partial words.
module uart_word_assembler
  import uart_word_assembler_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEF,
  parameter int NB_BYTE        = NB_BYTE_DEF,
  parameter int NB_TIMEOUT     = NB_TIMEOUT_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic [NB_BYTE-1:0] i_rx_byte,
  input  logic               i_rx_byte_done,
  input  logic               i_word_ready,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_word_valid,
  output logic [1:0]         o_byte_count,
  output logic               o_overrun,
  output logic               o_timeout,
  output logic [15:0]        o_word_count
);

  localparam int         BPW       = NB_DATA / NB_BYTE;
  localparam logic [1:0] LAST_BYTE = 2'(BPW - 1);

  if ((NB_DATA % NB_BYTE) != 0 || BPW < 2 || BPW > 4) begin : g_bad_width
    $error("NB_DATA must be 2..4 times NB_BYTE");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** NB_TIMEOUT) - 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range for NB_TIMEOUT");
  end

  rx_state_e          state_q;
  logic [1:0]         byte_cnt_q;
  logic [NB_DATA-1:0] shreg_q;
  logic [NB_DATA-1:0] word_d;
  logic [NB_DATA-1:0] word_q;
  logic               valid_q;
  logic [15:0]        word_cnt_q;
  logic               overrun_q;
  logic               timeout_q;
  logic               tmo_expired;

  // Partial word with the incoming byte placed at its final lane.
  always_comb begin
    word_d = shreg_q;
    word_d[int'(byte_cnt_q) * NB_BYTE +: NB_BYTE] = i_rx_byte;
  end

`ifdef UART_WORD_ASSEMBLER_TIMEOUT_EN
  logic tmo_clear;
  logic tmo_run;

  assign tmo_clear = i_clear | i_rx_byte_done | (state_q == ST_IDLE);
  assign tmo_run   = (state_q == ST_COLLECT) & ~i_rx_byte_done & ~i_clear;

  rx_timeout_counter #(
    .NB_TIMEOUT    (NB_TIMEOUT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx_timeout_counter (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (tmo_clear),
    .i_run    (tmo_run),
    .o_expired(tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      word_cnt_q <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      if (i_clear) begin
        state_q    <= ST_IDLE;
        byte_cnt_q <= '0;
        shreg_q    <= '0;
        valid_q    <= 1'b0;
      end else begin
        if (valid_q && i_word_ready) begin
          valid_q <= 1'b0;
        end
        case (state_q)
          ST_IDLE: begin
            if (i_rx_byte_done) begin
              shreg_q    <= word_d;
              byte_cnt_q <= 2'd1;
              state_q    <= ST_COLLECT;
            end
          end
          ST_COLLECT: begin
            if (i_rx_byte_done) begin
              if (byte_cnt_q == LAST_BYTE) begin
                state_q    <= ST_IDLE;
                byte_cnt_q <= '0;
                shreg_q    <= '0;
                // A completing word may replace one being consumed this same cycle.
                if (!valid_q || i_word_ready) begin
                  word_q     <= word_d;
                  valid_q    <= 1'b1;
                  word_cnt_q <= word_cnt_q + 1'b1;
                end else begin
                  overrun_q <= 1'b1;
                end
              end else begin
                shreg_q    <= word_d;
                byte_cnt_q <= byte_cnt_q + 1'b1;
              end
            end else if (tmo_expired) begin
              state_q    <= ST_IDLE;
              byte_cnt_q <= '0;
              shreg_q    <= '0;
              timeout_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = valid_q;
  assign o_byte_count = byte_cnt_q;
  assign o_overrun    = overrun_q;
  assign o_timeout    = timeout_q;
  assign o_word_count = word_cnt_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Scoreboard bench for uart_word_assembler; timeout cases depend on
// UART_WORD_ASSEMBLER_TIMEOUT_EN.
module tb_uart_word_assembler;
  import uart_word_assembler_pkg::*;

  localparam int TMO = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  rxb = 8'h00;
  logic        done = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] o_word;
  logic        o_word_valid;
  logic [1:0]  o_byte_count;
  logic        o_overrun;
  logic        o_timeout;
  logic [15:0] o_word_count;

  int          total = 0;
  int          bad = 0;
  logic [31:0] sb[$];
  logic [15:0] exp_cnt = '0;

  uart_word_assembler #(
    .NB_DATA       (NB_DATA_DEF),
    .NB_BYTE       (NB_BYTE_DEF),
    .NB_TIMEOUT    (16),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_clear       (clr),
    .i_rx_byte     (rxb),
    .i_rx_byte_done(done),
    .i_word_ready  (ready),
    .o_word        (o_word),
    .o_word_valid  (o_word_valid),
    .o_byte_count  (o_byte_count),
    .o_overrun     (o_overrun),
    .o_timeout     (o_timeout),
    .o_word_count  (o_word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxb  = b;
    done = 1'b1;
    tick();
    done = 1'b0;
    rxb  = 8'h00;
  endtask

  // Pushes the expectation just before the completing byte is driven.
  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 3; k++) send_byte(w[8*k +: 8]);
    sb.push_back(w);
    send_byte(w[31:24]);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_word"}, o_word, 32'h0);
    chk({pfx, "_valid"}, 32'(o_word_valid), 32'd0);
    chk({pfx, "_bcnt"}, 32'(o_byte_count), 32'd0);
    chk({pfx, "_ovr"}, 32'(o_overrun), 32'd0);
    chk({pfx, "_tmo"}, 32'(o_timeout), 32'd0);
    chk({pfx, "_wcnt"}, 32'(o_word_count), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && o_word_valid && ready) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'(sb.size()), 32'd1);
      end else begin
        chk("sb_word", o_word, sb.pop_front());
      end
    end
  end

  initial begin
    repeat (3) tick();
    chk_all_zero("rst");
    rst_n = 1'b1;
    tick();

    // Basic word, consumer always ready
    ready = 1'b1;
    send_byte(8'h78);
    chk("t1_bcnt1", 32'(o_byte_count), 32'd1);
    send_byte(8'h56);
    send_byte(8'h34);
    chk("t1_bcnt3", 32'(o_byte_count), 32'd3);
    sb.push_back(32'h12345678);
    send_byte(8'h12);
    exp_cnt++;
    chk("t1_valid", 32'(o_word_valid), 32'd1);
    chk("t1_word", o_word, 32'h12345678);
    chk("t1_wcnt", 32'(o_word_count), 32'(exp_cnt));
    chk("t1_bcnt0", 32'(o_byte_count), 32'd0);
    tick();
    chk("t1_valid_drop", 32'(o_word_valid), 32'd0);

    // Overrun under back-pressure
    ready = 1'b0;
    send_word(32'hAABBCCDD);
    exp_cnt++;
    send_byte(8'h44);
    send_byte(8'h33);
    send_byte(8'h22);
    chk("t2_ovr_early", 32'(o_overrun), 32'd0);
    send_byte(8'h11);
    chk("t2_ovr", 32'(o_overrun), 32'd1);
    chk("t2_word", o_word, 32'hAABBCCDD);
    chk("t2_wcnt", 32'(o_word_count), 32'(exp_cnt));
    chk("t2_valid", 32'(o_word_valid), 32'd1);
    tick();
    chk("t2_ovr_pulse", 32'(o_overrun), 32'd0);
    ready = 1'b1;
    tick();
    chk("t2_valid_drop", 32'(o_word_valid), 32'd0);

    // Accept and complete in the same cycle
    ready = 1'b0;
    send_word(32'hCAFEF00D);
    exp_cnt++;
    send_byte(8'hEF);
    send_byte(8'hCD);
    send_byte(8'hAB);
    sb.push_back(32'h89ABCDEF);
    ready = 1'b1;
    send_byte(8'h89);
    exp_cnt++;
    chk("t3_valid", 32'(o_word_valid), 32'd1);
    chk("t3_word", o_word, 32'h89ABCDEF);
    chk("t3_wcnt", 32'(o_word_count), 32'(exp_cnt));
    chk("t3_ovr", 32'(o_overrun), 32'd0);
    tick();
    chk("t3_valid_drop", 32'(o_word_valid), 32'd0);

    // Synchronous clear with a partial word and a held output
    ready = 1'b0;
    send_word(32'h0BADBEEF);
    exp_cnt++;
    send_byte(8'h01);
    send_byte(8'h02);
    chk("t4_bcnt_pre", 32'(o_byte_count), 32'd2);
    chk("t4_valid_pre", 32'(o_word_valid), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    sb.delete();
    chk("t4_bcnt", 32'(o_byte_count), 32'd0);
    chk("t4_valid", 32'(o_word_valid), 32'd0);
    chk("t4_wcnt", 32'(o_word_count), 32'(exp_cnt));
    ready = 1'b1;
    send_word(32'h13579BDF);
    exp_cnt++;
    chk("t4_word_after", o_word, 32'h13579BDF);
    tick();

`ifdef UART_WORD_ASSEMBLER_TIMEOUT_EN
    // Stale partial word is discarded after TMO idle clocks
    send_byte(8'hEE);
    send_byte(8'hFF);
    repeat (TMO - 1) tick();
    chk("t5_tmo_early", 32'(o_timeout), 32'd0);
    chk("t5_bcnt_early", 32'(o_byte_count), 32'd2);
    tick();
    chk("t5_tmo", 32'(o_timeout), 32'd1);
    chk("t5_bcnt", 32'(o_byte_count), 32'd0);
    tick();
    chk("t5_tmo_pulse", 32'(o_timeout), 32'd0);
    send_word(32'h04030201);
    exp_cnt++;
    chk("t5_word", o_word, 32'h04030201);
    tick();

    // A byte on the expiry cycle wins over the timeout
    send_byte(8'hA1);
    send_byte(8'hA2);
    repeat (TMO - 1) tick();
    send_byte(8'hA3);
    chk("t6_tmo", 32'(o_timeout), 32'd0);
    chk("t6_bcnt", 32'(o_byte_count), 32'd3);
    tick();
    chk("t6_tmo_after", 32'(o_timeout), 32'd0);
    sb.push_back(32'hA4A3A2A1);
    send_byte(8'hA4);
    exp_cnt++;
    chk("t6_word", o_word, 32'hA4A3A2A1);
    tick();
`else
    // Without the timeout a partial word is held indefinitely
    send_byte(8'hA1);
    send_byte(8'hA2);
    repeat (3 * TMO) tick();
    chk("t5_tmo", 32'(o_timeout), 32'd0);
    chk("t5_bcnt", 32'(o_byte_count), 32'd2);
    send_byte(8'hA3);
    sb.push_back(32'hA4A3A2A1);
    send_byte(8'hA4);
    exp_cnt++;
    chk("t5_word", o_word, 32'hA4A3A2A1);
    chk("t5_wcnt", 32'(o_word_count), 32'(exp_cnt));
    tick();
`endif

    // Asynchronous reset in the middle of a word
    ready = 1'b0;
    send_word(32'hDEADBEEF);
    exp_cnt++;
    send_byte(8'h55);
    chk("t7_valid_pre", 32'(o_word_valid), 32'd1);
    chk("t7_wcnt_pre", 32'(o_word_count), 32'(exp_cnt));
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("t7");
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();

    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
